ifetch_unit: RTL and testbench
==============================

// Module: ifetch_unit
// PURPOSE
//  Instruction fetch stage directly upstream of the instruction cache. Owns the PC,
//  issues one request at a time on the icache mem_* interface and buffers returned
//  instructions in a small FIFO. Presents {pc, instr} to decode on a valid/ready
//  handshake and handles redirects (jump, exception, cache flush) with in-flight kill.
// PARAMETERS
//  RESET_PC    16'h0000  PC loaded on reset; word (32-bit instruction) address
//  FIFO_DEPTH  2         prefetch entries; power of two, >= 2
// PORTS
//  i_clk              in   1   clock
//  i_rst              in   1   reset: synchronous, active-high
//  i_redirect         in   1   one-cycle pulse; load i_redirect_pc, kill everything younger
//  i_redirect_pc      in   16  new fetch address (RW)
//  i_redirect_flush   in   1   qualifies i_redirect; also invalidate icache
//  o_valid            out  1   decode-side entry valid
//  i_ready            in   1   decode accepts entry when o_valid & i_ready
//  o_instr            out  32  instruction (I_SIZE)
//  o_pc               out  16  address of o_instr
//  mem_req            out  1   to icache: fetch enabled
//  mem_addr           out  16  to icache: request address
//  mem_ppl_submit     out  1   to icache: one-cycle request submit pulse
//  mem_cache_flush    out  1   to icache: invalidate all lines
//  mem_ack            in   1   from icache: mem_data valid this cycle
//  mem_data           in   32  from icache: instruction
// BEHAVIOUR
//  Reset: pc=RESET_PC, FIFO empty, o_valid=0, mem_req=0, mem_ppl_submit=0,
//   mem_cache_flush=0, mem_addr=RESET_PC, state=IDLE, kill=0. Reset wins over all.
//  mem_req=1 in every cycle after reset release. At most one request outstanding.
//  Credit: issue only if fifo_count + outstanding < FIFO_DEPTH; a FIFO pop in the
//   same cycle does not create a credit (no pop-to-issue bypass).
//  FSM: IDLE  -> WAIT on issue: mem_ppl_submit=1 for 1 cycle, mem_addr=pc, pc<=pc+1
//              (16-bit wrap 16'hFFFF->16'h0000). mem_addr held stable until ack.
//       WAIT  -> IDLE on mem_ack. Ack with kill=0: push {mem_addr, mem_data}; kill=1:
//              drop data, clear kill. Same cycle as ack, IDLE issue is allowed next cycle.
//  Latency: ack at cycle N -> o_valid=1 at N+1 (registered FIFO output, no bypass).
//   Back-to-back hits: one instruction per 2 cycles (submit, ack); FIFO hides stalls.
//  Redirect (cycle N): FIFO cleared, pc<=i_redirect_pc; in WAIT, kill<=1 unless mem_ack
//   in cycle N (that ack is dropped directly). New submit no earlier than N+1; in WAIT,
//   first cycle after the killed ack. o_valid=0 at N+1.
//  i_redirect_flush: mem_cache_flush=1 in cycle N only (combinational with i_redirect);
//   ignored without i_redirect.
//  Redirect + decode pop in cycle N: pop completes, then flush; no double handshake.
//  Redirect with FIFO full: allowed, same rules. Redirect in IDLE: no kill.
//  o_instr/o_pc don't-care while o_valid=0; stable while o_valid & ~i_ready.
// STRUCTURE
//  RW=16, I_SIZE=32 taken from config.v; no new globals. State encodings local.
//  Sub-module ifetch_fifo: synchronous FIFO of {pc,instr}, push/pop/clear, count
//   output; clear has priority over push. FSM, PC and kill flag live in ifetch_unit.
// TESTING
//  1 Reset release, icache acks each submit 1 cycle later, i_ready=1 -> o_pc=0,1,2,3
//    with matching instr, submits every 2 cycles, no gaps after warm-up.
//  2 i_ready=0 for 10 cycles -> exactly FIFO_DEPTH submits, then mem_ppl_submit=0;
//    on i_ready=1 drains in order, fetch resumes.
//  3 Redirect to 16'h0100 while WAIT (ack 5 cycles later, icache miss) -> killed ack
//    not presented; next submit addr=16'h0100; first o_pc=16'h0100.
//  4 Redirect in same cycle as mem_ack -> that data dropped, kill stays 0, next ack
//    accepted normally.
//  5 Redirect+flush -> mem_cache_flush pulse 1 cycle, FIFO empty next cycle, refetch
//    from new pc.
//  6 pc=16'hFFFF fetched -> next submit mem_addr=16'h0000; reset asserted mid-WAIT ->
//    all outputs at reset values next cycle, late ack ignored.

Source files
------------

// File: rtl/ifetch_unit_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : ifetch_unit_pkg
//  Purpose  : Shared widths, the prefetch entry type and the PC increment
//             helper for the instruction fetch stage.
//  Contents : RW (address width), I_SIZE (instruction width),
//             fetch_entry_t {pc, instr}, pc_incr()
//  Revision : 1.0 - initial release
// ============================================================================
package ifetch_unit_pkg;

    localparam int RW     = 16;
    localparam int I_SIZE = 32;

    typedef struct packed {
        logic [RW-1:0]     pc;
        logic [I_SIZE-1:0] instr;
    } fetch_entry_t;

    // Word-address increment; wraps 16'hFFFF -> 16'h0000 by width truncation.
    function automatic logic [RW-1:0] pc_incr(input logic [RW-1:0] pc);
        return pc + RW'(1);
    endfunction

endpackage
`default_nettype wire

// File: rtl/ifetch_unit_if.sv
`default_nettype none
// ============================================================================
//  Module   : ifetch_unit_if
//  Purpose  : Fetch-to-icache request/response bundle.
//  Signals  : mem_req         fetch enabled
//             mem_addr        request word address, held until ack
//             mem_ppl_submit  one-cycle request submit pulse
//             mem_cache_flush invalidate all icache lines
//             mem_ack         mem_data valid this cycle
//             mem_data        returned instruction
//  Modports : master (fetch unit), slave (icache)
//  Revision : 1.0 - initial release
// ============================================================================
interface ifetch_unit_if;
    import ifetch_unit_pkg::*;

    logic              mem_req;
    logic [RW-1:0]     mem_addr;
    logic              mem_ppl_submit;
    logic              mem_cache_flush;
    logic              mem_ack;
    logic [I_SIZE-1:0] mem_data;

    modport master (
        output mem_req, mem_addr, mem_ppl_submit, mem_cache_flush,
        input  mem_ack, mem_data
    );

    modport slave (
        input  mem_req, mem_addr, mem_ppl_submit, mem_cache_flush,
        output mem_ack, mem_data
    );

endinterface
`default_nettype wire

// File: rtl/ifetch_unit_fifo.sv
`default_nettype none
// ============================================================================
//  Module   : ifetch_unit_fifo
//  Purpose  : Synchronous prefetch FIFO of {pc, instr}. Head entry is read
//             straight from registered storage (no write-to-read bypass).
//             Clear has priority over push and pop.
//  Ports    : i_clk, i_rst         clock, synchronous active-high reset
//             i_push, i_wdata      write an entry (ignored when full)
//             i_pop                retire head entry (ignored when empty)
//             i_clear              drop all entries
//             o_rdata              head entry
//             o_count, o_empty     occupancy
//  Revision : 1.0 - initial release
// ============================================================================
module ifetch_unit_fifo #(
    parameter int DEPTH = 2,
    parameter int WIDTH = 48
) (
    input  wire logic                       i_clk,
    input  wire logic                       i_rst,
    input  wire logic                       i_push,
    input  wire logic [WIDTH-1:0]           i_wdata,
    input  wire logic                       i_pop,
    input  wire logic                       i_clear,
    output logic      [WIDTH-1:0]           o_rdata,
    output logic      [$clog2(DEPTH):0]     o_count,
    output logic                            o_empty
);

    localparam int c_AW = $clog2(DEPTH);
    localparam int c_CW = $clog2(DEPTH) + 1;

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [c_AW-1:0]  r_wptr;
    logic [c_AW-1:0]  r_rptr;
    logic [c_CW-1:0]  r_count;

    logic w_full;
    logic w_do_push;
    logic w_do_pop;

    assign o_empty   = (r_count == '0);
    assign w_full    = (r_count == c_CW'(DEPTH));
    assign w_do_push = i_push & ~w_full;
    assign w_do_pop  = i_pop & ~o_empty;

    // Storage needs no reset: entries are only visible through the pointers.
    always_ff @(posedge i_clk) begin
        if (w_do_push) begin
            r_mem[r_wptr] <= i_wdata;
        end
    end

    // DEPTH is a power of two, so the pointers wrap by truncation.
    always_ff @(posedge i_clk) begin
        if (i_rst || i_clear) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
        end else begin
            if (w_do_push) begin
                r_wptr <= r_wptr + c_AW'(1);
            end
            if (w_do_pop) begin
                r_rptr <= r_rptr + c_AW'(1);
            end
            case ({w_do_push, w_do_pop})
                2'b10:   r_count <= r_count + c_CW'(1);
                2'b01:   r_count <= r_count - c_CW'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    assign o_rdata = r_mem[r_rptr];
    assign o_count = r_count;

endmodule
`default_nettype wire

// File: rtl/ifetch_unit.sv
`default_nettype none
// ============================================================================
//  Module   : ifetch_unit
//  Purpose  : Instruction fetch stage in front of the icache. Owns the PC,
//             keeps at most one icache request outstanding, buffers returned
//             instructions in a prefetch FIFO and hands {pc, instr} to decode
//             on a valid/ready handshake. Redirects reload the PC, empty the
//             FIFO and kill any request still in flight.
//  Ports    : i_clk, i_rst                        clock, sync active-high reset
//             i_redirect, i_redirect_pc,
//             i_redirect_flush                    redirect (optionally flush)
//             o_valid, i_ready, o_instr, o_pc     decode handshake
//             mem (ifetch_unit_if.master)         icache request bus
//  Revision : 1.0 - initial release
// ============================================================================
module ifetch_unit
    import ifetch_unit_pkg::*;
#(
    parameter logic [15:0] RESET_PC   = 16'h0000,
    parameter int          FIFO_DEPTH = 2
) (
    input  wire logic              i_clk,
    input  wire logic              i_rst,
    input  wire logic              i_redirect,
    input  wire logic [RW-1:0]     i_redirect_pc,
    input  wire logic              i_redirect_flush,
    output logic                   o_valid,
    input  wire logic              i_ready,
    output logic      [I_SIZE-1:0] o_instr,
    output logic      [RW-1:0]     o_pc,
    ifetch_unit_if.master          mem
);

    localparam int c_CW = $clog2(FIFO_DEPTH) + 1;

    localparam logic [0:0] c_IDLE = 1'b0;
    localparam logic [0:0] c_WAIT = 1'b1;

    logic [0:0]      r_state;
    logic [0:0]      w_state_nxt;
    logic [RW-1:0]   r_pc;
    logic [RW-1:0]   r_addr;
    logic            r_kill;
    logic            r_req;

    logic [c_CW-1:0] w_count;
    logic            w_empty;
    logic [c_CW-1:0] w_inflight;
    logic            w_credit;
    logic            w_issue;
    logic            w_ack;
    logic            w_push;
    logic            w_pop;
    fetch_entry_t    w_push_entry;
    fetch_entry_t    w_head;

    // Credit uses the current occupancy only; a pop this cycle frees a slot
    // from the next cycle on.
    assign w_inflight = w_count + c_CW'(r_state == c_WAIT);
    assign w_credit   = (w_inflight < c_CW'(FIFO_DEPTH));

    // A redirect cycle never issues: the new PC is only valid next cycle.
    assign w_issue = (r_state == c_IDLE) & r_req & ~i_rst & ~i_redirect & w_credit;

    // Acks are only meaningful while a request is outstanding; anything
    // arriving in IDLE (e.g. a late reply across a reset) is ignored.
    assign w_ack  = (r_state == c_WAIT) & mem.mem_ack;
    assign w_push = w_ack & ~r_kill & ~i_redirect;
    assign w_pop  = o_valid & i_ready;

    assign w_push_entry = '{pc: r_addr, instr: mem.mem_data};

    // ---------------- FSM: state register ----------------
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state <= c_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // ---------------- FSM: next state ----------------
    // A redirect in WAIT without an ack stays in WAIT; the kill flag
    // swallows the reply when it eventually arrives.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            c_IDLE:  if (w_issue)      w_state_nxt = c_WAIT;
            c_WAIT:  if (mem.mem_ack)  w_state_nxt = c_IDLE;
            default: w_state_nxt = c_IDLE;
        endcase
    end

    // ---------------- FSM: outputs ----------------
    always_comb begin
        mem.mem_req         = r_req;
        mem.mem_ppl_submit  = w_issue;
        mem.mem_addr        = (r_state == c_WAIT) ? r_addr : r_pc;
        mem.mem_cache_flush = i_redirect & i_redirect_flush & ~i_rst;
    end

    // ---------------- PC, held request address, kill flag ----------------
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_pc   <= RESET_PC;
            r_addr <= RESET_PC;
            r_kill <= 1'b0;
            r_req  <= 1'b0;
        end else begin
            r_req <= 1'b1;

            if (i_redirect) begin
                r_pc <= i_redirect_pc;
            end else if (w_issue) begin
                r_pc <= pc_incr(r_pc);
            end

            if (w_issue) begin
                r_addr <= r_pc;
            end

            // An ack coinciding with the redirect is dropped directly, so the
            // flag is only armed when the reply is still to come.
            if (w_ack) begin
                r_kill <= 1'b0;
            end else if (i_redirect && (r_state == c_WAIT)) begin
                r_kill <= 1'b1;
            end
        end
    end

    ifetch_unit_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH ($bits(fetch_entry_t))
    ) u_fifo (
        .i_clk   (i_clk),
        .i_rst   (i_rst),
        .i_push  (w_push),
        .i_wdata (w_push_entry),
        .i_pop   (w_pop),
        .i_clear (i_redirect),
        .o_rdata (w_head),
        .o_count (w_count),
        .o_empty (w_empty)
    );

    assign o_valid = ~w_empty;
    assign o_pc    = w_head.pc;
    assign o_instr = w_head.instr;

endmodule
`default_nettype wire

// File: tb/tb_ifetch_unit.sv
`default_nettype none
// ============================================================================
//  Module   : tb_ifetch_unit
//  Purpose  : Directed self-checking bench for ifetch_unit with a simple
//             icache responder of programmable latency.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_ifetch_unit;
    import ifetch_unit_pkg::*;

    logic              clk = 1'b0;
    logic              i_rst;
    logic              i_redirect;
    logic [RW-1:0]     i_redirect_pc;
    logic              i_redirect_flush;
    logic              o_valid;
    logic              i_ready;
    logic [I_SIZE-1:0] o_instr;
    logic [RW-1:0]     o_pc;

    int n_tests = 0;
    int n_fail  = 0;

    // icache responder controls and state
    logic              rsp_en;
    int                lat;
    logic              rsp_ack = 1'b0;
    logic [I_SIZE-1:0] rsp_data = '0;
    logic              man_ack;
    logic [I_SIZE-1:0] man_data;
    logic              sub_seen = 1'b0;
    logic [RW-1:0]     sub_addr = '0;
    logic              pend = 1'b0;
    logic [RW-1:0]     pend_addr = '0;
    int                cd = 0;

    ifetch_unit_if mem_bus ();

    assign mem_bus.mem_ack  = rsp_ack | man_ack;
    assign mem_bus.mem_data = man_ack ? man_data : rsp_data;

    ifetch_unit #(
        .RESET_PC   (16'h0000),
        .FIFO_DEPTH (2)
    ) dut (
        .i_clk            (clk),
        .i_rst            (i_rst),
        .i_redirect       (i_redirect),
        .i_redirect_pc    (i_redirect_pc),
        .i_redirect_flush (i_redirect_flush),
        .o_valid          (o_valid),
        .i_ready          (i_ready),
        .o_instr          (o_instr),
        .o_pc             (o_pc),
        .mem              (mem_bus)
    );

    always #5 clk = ~clk;

    function automatic logic [I_SIZE-1:0] icache_word(input logic [RW-1:0] a);
        return {a ^ 16'h5A5A, ~a};
    endfunction

    always @(negedge clk) begin
        sub_seen = mem_bus.mem_ppl_submit;
        sub_addr = mem_bus.mem_addr;
    end

    // Ack arrives 'lat' cycles after the submit cycle.
    always @(posedge clk) begin
        #2;
        rsp_ack = 1'b0;
        if (!rsp_en) begin
            pend = 1'b0;
        end else begin
            if (sub_seen) begin
                pend      = 1'b1;
                pend_addr = sub_addr;
                cd        = lat;
            end
            if (pend) begin
                if (cd <= 1) begin
                    rsp_ack  = 1'b1;
                    rsp_data = icache_word(pend_addr);
                    pend     = 1'b0;
                end else begin
                    cd = cd - 1;
                end
            end
        end
    end

    task automatic do_reset(input int n);
        i_rst = 1'b1; i_redirect = 1'b0; i_redirect_flush = 1'b0;
        i_redirect_pc = '0; i_ready = 1'b0; man_ack = 1'b0; man_data = '0;
        rsp_en = 1'b1; lat = 1;
        repeat (n) @(posedge clk);
        #1;
        i_rst = 1'b0;
    endtask

    task automatic test_reset();
        i_rst = 1'b1; i_redirect = 1'b1; i_redirect_flush = 1'b1;
        i_redirect_pc = 16'h1234; i_ready = 1'b0; man_ack = 1'b0; man_data = '0;
        rsp_en = 1'b1; lat = 1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        n_tests++; if (o_valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid: got %b want 0", o_valid); end
        n_tests++; if (mem_bus.mem_req !== 1'b0) begin n_fail++; $display("FAIL reset_req: got %b want 0", mem_bus.mem_req); end
        n_tests++; if (mem_bus.mem_ppl_submit !== 1'b0) begin n_fail++; $display("FAIL reset_submit: got %b want 0", mem_bus.mem_ppl_submit); end
        n_tests++; if (mem_bus.mem_cache_flush !== 1'b0) begin n_fail++; $display("FAIL reset_flush: got %b want 0", mem_bus.mem_cache_flush); end
        n_tests++; if (mem_bus.mem_addr !== 16'h0000) begin n_fail++; $display("FAIL reset_addr: got %h want 0000", mem_bus.mem_addr); end
        @(posedge clk); #1;
    endtask

    task automatic test_stream();
        logic          exp_sub, exp_v;
        logic [RW-1:0] exp_pc;
        do_reset(6);
        i_ready = 1'b1;
        for (int c = 0; c <= 10; c++) begin
            @(negedge clk);
            exp_sub = (c % 2 == 1);
            exp_v   = (c >= 3) && (c % 2 == 1);
            n_tests++; if (mem_bus.mem_req !== (c >= 1)) begin n_fail++; $display("FAIL stream_req c%0d: got %b want %b", c, mem_bus.mem_req, (c >= 1)); end
            n_tests++; if (mem_bus.mem_ppl_submit !== exp_sub) begin n_fail++; $display("FAIL stream_submit c%0d: got %b want %b", c, mem_bus.mem_ppl_submit, exp_sub); end
            if (exp_sub) begin
                exp_pc = RW'((c - 1) / 2);
                n_tests++; if (mem_bus.mem_addr !== exp_pc) begin n_fail++; $display("FAIL stream_addr c%0d: got %h want %h", c, mem_bus.mem_addr, exp_pc); end
            end
            n_tests++; if (o_valid !== exp_v) begin n_fail++; $display("FAIL stream_valid c%0d: got %b want %b", c, o_valid, exp_v); end
            if (exp_v) begin
                exp_pc = RW'((c - 3) / 2);
                n_tests++; if (o_pc !== exp_pc) begin n_fail++; $display("FAIL stream_pc c%0d: got %h want %h", c, o_pc, exp_pc); end
                n_tests++; if (o_instr !== icache_word(exp_pc)) begin n_fail++; $display("FAIL stream_instr c%0d: got %h want %h", c, o_instr, icache_word(exp_pc)); end
            end
            @(posedge clk); #1;
        end
    endtask

    task automatic test_stall();
        int nsub = 0;
        do_reset(6);
        for (int c = 0; c <= 13; c++) begin
            i_ready = (c >= 10);
            @(negedge clk);
            if (c < 10 && mem_bus.mem_ppl_submit === 1'b1) nsub++;
            if (c == 9) begin
                n_tests++; if (nsub != 2) begin n_fail++; $display("FAIL stall_nsub: got %0d want 2", nsub); end
                n_tests++; if (mem_bus.mem_ppl_submit !== 1'b0) begin n_fail++; $display("FAIL stall_submit: got %b want 0", mem_bus.mem_ppl_submit); end
                n_tests++; if (o_valid !== 1'b1 || o_pc !== 16'h0000) begin n_fail++; $display("FAIL stall_hold: got v=%b pc=%h want v=1 pc=0000", o_valid, o_pc); end
            end
            if (c == 10) begin
                n_tests++; if (o_valid !== 1'b1 || o_pc !== 16'h0000) begin n_fail++; $display("FAIL drain0: got v=%b pc=%h want v=1 pc=0000", o_valid, o_pc); end
            end
            if (c == 11) begin
                n_tests++; if (o_valid !== 1'b1 || o_pc !== 16'h0001) begin n_fail++; $display("FAIL drain1: got v=%b pc=%h want v=1 pc=0001", o_valid, o_pc); end
                n_tests++; if (mem_bus.mem_ppl_submit !== 1'b1 || mem_bus.mem_addr !== 16'h0002) begin n_fail++; $display("FAIL resume_submit: got s=%b a=%h want s=1 a=0002", mem_bus.mem_ppl_submit, mem_bus.mem_addr); end
            end
            if (c == 12) begin
                n_tests++; if (o_valid !== 1'b0) begin n_fail++; $display("FAIL drain_gap: got %b want 0", o_valid); end
            end
            if (c == 13) begin
                n_tests++; if (o_valid !== 1'b1 || o_pc !== 16'h0002 || o_instr !== icache_word(16'h0002)) begin n_fail++; $display("FAIL resume_data: got v=%b pc=%h i=%h want v=1 pc=0002", o_valid, o_pc, o_instr); end
            end
            @(posedge clk); #1;
        end
    endtask

    task automatic test_redirect_wait();
        do_reset(6);
        lat = 5;
        i_ready = 1'b1;
        i_redirect_pc = 16'h0100;
        for (int c = 0; c <= 13; c++) begin
            i_redirect = (c == 3);
            @(negedge clk);
            if (c >= 2 && c <= 6) begin
                n_tests++; if (mem_bus.mem_ppl_submit !== 1'b0) begin n_fail++; $display("FAIL rdw_nosubmit c%0d: got %b want 0", c, mem_bus.mem_ppl_submit); end
            end
            if (c == 4) begin
                n_tests++; if (mem_bus.mem_addr !== 16'h0000) begin n_fail++; $display("FAIL rdw_addr_hold: got %h want 0000", mem_bus.mem_addr); end
            end
            if (c == 7) begin
                n_tests++; if (o_valid !== 1'b0) begin n_fail++; $display("FAIL rdw_killed: got %b want 0", o_valid); end
                n_tests++; if (mem_bus.mem_ppl_submit !== 1'b1 || mem_bus.mem_addr !== 16'h0100) begin n_fail++; $display("FAIL rdw_submit: got s=%b a=%h want s=1 a=0100", mem_bus.mem_ppl_submit, mem_bus.mem_addr); end
            end
            if (c == 12) begin
                n_tests++; if (o_valid !== 1'b0) begin n_fail++; $display("FAIL rdw_early: got %b want 0", o_valid); end
            end
            if (c == 13) begin
                n_tests++; if (o_valid !== 1'b1 || o_pc !== 16'h0100 || o_instr !== icache_word(16'h0100)) begin n_fail++; $display("FAIL rdw_first: got v=%b pc=%h i=%h want v=1 pc=0100", o_valid, o_pc, o_instr); end
            end
            @(posedge clk); #1;
        end
        i_redirect = 1'b0;
    endtask

    task automatic test_redirect_ack();
        do_reset(6);
        i_ready = 1'b1;
        i_redirect_pc = 16'h0200;
        for (int c = 0; c <= 5; c++) begin
            i_redirect = (c == 2);
            @(negedge clk);
            if (c == 3) begin
                n_tests++; if (o_valid !== 1'b0) begin n_fail++; $display("FAIL rda_dropped: got %b want 0", o_valid); end
                n_tests++; if (mem_bus.mem_ppl_submit !== 1'b1 || mem_bus.mem_addr !== 16'h0200) begin n_fail++; $display("FAIL rda_submit: got s=%b a=%h want s=1 a=0200", mem_bus.mem_ppl_submit, mem_bus.mem_addr); end
            end
            if (c == 5) begin
                n_tests++; if (o_valid !== 1'b1 || o_pc !== 16'h0200 || o_instr !== icache_word(16'h0200)) begin n_fail++; $display("FAIL rda_next: got v=%b pc=%h i=%h want v=1 pc=0200", o_valid, o_pc, o_instr); end
            end
            @(posedge clk); #1;
        end
        i_redirect = 1'b0;
    endtask

    task automatic test_flush();
        do_reset(6);
        i_redirect_pc = 16'h0300;
        for (int c = 0; c <= 8; c++) begin
            i_redirect_flush = (c == 4) || (c == 5);
            i_redirect       = (c == 5);
            @(negedge clk);
            if (c == 4) begin
                n_tests++; if (mem_bus.mem_cache_flush !== 1'b0) begin n_fail++; $display("FAIL flush_noredir: got %b want 0", mem_bus.mem_cache_flush); end
            end
            if (c == 5) begin
                n_tests++; if (mem_bus.mem_cache_flush !== 1'b1) begin n_fail++; $display("FAIL flush_pulse: got %b want 1", mem_bus.mem_cache_flush); end
                n_tests++; if (o_valid !== 1'b1) begin n_fail++; $display("FAIL flush_full: got %b want 1", o_valid); end
            end
            if (c == 6) begin
                n_tests++; if (mem_bus.mem_cache_flush !== 1'b0) begin n_fail++; $display("FAIL flush_end: got %b want 0", mem_bus.mem_cache_flush); end
                n_tests++; if (o_valid !== 1'b0) begin n_fail++; $display("FAIL flush_empty: got %b want 0", o_valid); end
                n_tests++; if (mem_bus.mem_ppl_submit !== 1'b1 || mem_bus.mem_addr !== 16'h0300) begin n_fail++; $display("FAIL flush_refetch: got s=%b a=%h want s=1 a=0300", mem_bus.mem_ppl_submit, mem_bus.mem_addr); end
            end
            if (c == 8) begin
                n_tests++; if (o_valid !== 1'b1 || o_pc !== 16'h0300 || o_instr !== icache_word(16'h0300)) begin n_fail++; $display("FAIL flush_data: got v=%b pc=%h i=%h want v=1 pc=0300", o_valid, o_pc, o_instr); end
            end
            @(posedge clk); #1;
        end
        i_redirect = 1'b0;
        i_redirect_flush = 1'b0;
    endtask

    task automatic test_wrap_reset();
        do_reset(6);
        i_ready = 1'b1;
        i_redirect_pc = 16'hFFFF;
        man_data = 32'hDEAD_BEEF;
        for (int c = 0; c <= 8; c++) begin
            i_redirect = (c == 0);
            rsp_en     = (c < 5);
            i_rst      = (c == 6);
            man_ack    = (c == 7);
            @(negedge clk);
            if (c == 1) begin
                n_tests++; if (mem_bus.mem_ppl_submit !== 1'b1 || mem_bus.mem_addr !== 16'hFFFF) begin n_fail++; $display("FAIL wrap_top: got s=%b a=%h want s=1 a=ffff", mem_bus.mem_ppl_submit, mem_bus.mem_addr); end
            end
            if (c == 3) begin
                n_tests++; if (mem_bus.mem_ppl_submit !== 1'b1 || mem_bus.mem_addr !== 16'h0000) begin n_fail++; $display("FAIL wrap_next: got s=%b a=%h want s=1 a=0000", mem_bus.mem_ppl_submit, mem_bus.mem_addr); end
                n_tests++; if (o_valid !== 1'b1 || o_pc !== 16'hFFFF) begin n_fail++; $display("FAIL wrap_out: got v=%b pc=%h want v=1 pc=ffff", o_valid, o_pc); end
            end
            if (c == 5) begin
                n_tests++; if (o_valid !== 1'b1 || o_pc !== 16'h0000) begin n_fail++; $display("FAIL wrap_out0: got v=%b pc=%h want v=1 pc=0000", o_valid, o_pc); end
            end
            if (c == 7) begin
                n_tests++; if (mem_bus.mem_req !== 1'b0 || mem_bus.mem_ppl_submit !== 1'b0 || o_valid !== 1'b0) begin n_fail++; $display("FAIL rst_mid_ctl: got req=%b s=%b v=%b want 0 0 0", mem_bus.mem_req, mem_bus.mem_ppl_submit, o_valid); end
                n_tests++; if (mem_bus.mem_addr !== 16'h0000 || mem_bus.mem_cache_flush !== 1'b0) begin n_fail++; $display("FAIL rst_mid_addr: got a=%h f=%b want 0000 0", mem_bus.mem_addr, mem_bus.mem_cache_flush); end
            end
            if (c == 8) begin
                n_tests++; if (o_valid !== 1'b0) begin n_fail++; $display("FAIL late_ack: got %b want 0", o_valid); end
                n_tests++; if (mem_bus.mem_ppl_submit !== 1'b1 || mem_bus.mem_addr !== 16'h0000) begin n_fail++; $display("FAIL rst_refetch: got s=%b a=%h want s=1 a=0000", mem_bus.mem_ppl_submit, mem_bus.mem_addr); end
            end
            @(posedge clk); #1;
        end
        man_ack = 1'b0;
        i_redirect = 1'b0;
    endtask

    initial begin
        test_reset();
        test_stream();
        test_stall();
        test_redirect_wait();
        test_redirect_ack();
        test_flush();
        test_wrap_reset();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
